// File: rtl/unpack_pkg.sv
// Shared helpers for the wide-to-narrow unpacker.
package unpack_pkg;

  // Width of a lane index for a word of d lanes; never less than one bit.
  function automatic int idx_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/unpack_if.sv
// Stream bundle for the unpacker: a wide word port (s_*) feeding the block
// and a narrow lane port (m_*) leaving it.
//
// Handshake: both ports use stb/rdy. A transfer happens on a rising clock
// edge where stb and rdy are both high. Once stb is raised the source holds
// its data (and s_end / m_last) stable until the transfer; rdy may change
// freely and is allowed to depend combinationally on the other side's rdy.
interface unpack_if import unpack_pkg::*; #(
  parameter int W = 8,
  parameter int D = 2
);
  localparam int IW = idx_width(D);

  logic          s_stb;
  logic [W*D-1:0] s_dat;
  logic [IW-1:0] s_end;
  logic          s_rdy;
  logic          m_rdy;
  logic          m_stb;
  logic [W-1:0]  m_dat;
  logic          m_last;

  // Unpacker side: takes words in, sends lanes out.
  modport slave (
    input  s_stb, s_dat, s_end, m_rdy,
    output s_rdy, m_stb, m_dat, m_last
  );

  // Environment side: upstream word source plus downstream lane sink.
  modport master (
    output s_stb, s_dat, s_end, m_rdy,
    input  s_rdy, m_stb, m_dat, m_last
  );
endinterface

// File: rtl/unpack.sv
// Wide-to-narrow serializer. A word of D lanes is captured on accept and
// replayed one W-bit lane per cycle, lane 0 first. A word may be partial
// (s_end < D-1); the final lane is flagged with m_last. A new word can be
// accepted on the cycle the last lane leaves, so lanes stream without gaps.
// W and D must match the parameters of the connected interface.
module unpack import unpack_pkg::*; #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  unpack_if.slave  bus
);
  localparam int IW = idx_width(D);

  logic [W*D-1:0] buf_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  end_q;
  logic           stb_q;

  logic [IW-1:0]  end_in;
  logic           at_end;
  logic           accept;
  logic           xfer;

  assign at_end = (idx_q == end_q);
  assign xfer   = stb_q & bus.m_rdy;
  assign accept = bus.s_stb & bus.s_rdy;

  // The only input-to-output path: free the holding register when it is
  // empty or when its last lane is leaving this cycle.
  assign bus.s_rdy = ~stb_q | (bus.m_rdy & at_end);

  // Outputs are decoded purely from registers.
  assign bus.m_stb  = stb_q;
  assign bus.m_dat  = buf_q[W*idx_q +: W];
  assign bus.m_last = stb_q & at_end;

  // Out-of-range last-lane indices only exist when D is not a power of two.
  if ((1 << IW) > D) begin : g_clamp
    // Clamp the requested last lane to the top lane of the word.
    always_comb begin
      end_in = bus.s_end;
      if (bus.s_end > IW'(D - 1)) end_in = IW'(D - 1);
    end
  end else begin : g_pass
    assign end_in = bus.s_end;
  end

  // Holding register, lane counter and output valid; a word accept wins over
  // the retirement of the previous word's last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      idx_q <= '0;
      end_q <= '0;
      stb_q <= 1'b0;
    end else if (accept) begin
      buf_q <= bus.s_dat;
      idx_q <= '0;
      end_q <= end_in;
      stb_q <= 1'b1;
    end else if (xfer) begin
      if (at_end) begin
        idx_q <= '0;
        stb_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule
